// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer:
// command mode encodings and the sequencer state type.
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_ROR  = 2'b01;
  localparam logic [1:0] USR_ROL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } usr_state_e;

  function automatic logic is_rotate(input logic [1:0] mode);
    return (mode == USR_ROR) || (mode == USR_ROL);
  endfunction

endpackage

// File: rtl/usr_core.sv
// WIDTH-bit universal shift register: parallel load plus single-bit
// rotate right / rotate left. Load has priority over the rotate controls.
module usr_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ror,
  input  logic             rol,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (ror) begin
      q <= {q[0], q[WIDTH-1:1]};
    end else if (rol) begin
      q <= {q[WIDTH-2:0], q[WIDTH-1]};
    end
  end

endmodule

// File: rtl/usr_sequencer.sv
// Round-robin command sequencer for the universal shift register: accepts one
// command from two requesters, runs the requested rotations, returns the result.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_mode,
  input  logic [CNT_W-1:0] req0_count,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_mode,
  input  logic [CNT_W-1:0] req1_count,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held until ready.

  usr_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic             id_q;
  logic             last_grant;
  logic             grant_id;
  logic             accept;
  logic [1:0]       sel_mode;
  logic [CNT_W-1:0] sel_count;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] reg_q;
  logic             do_ror, do_rol;

  // last_grant resets to 1 so that the first contested grant goes to req0.
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    sel_mode   = grant_id ? req1_mode  : req0_mode;
    sel_count  = grant_id ? req1_count : req0_count;
    sel_data   = grant_id ? req1_data  : req0_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (is_rotate(sel_mode) && (sel_count != '0)) ? SHIFT : RESP;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_q     <= USR_HOLD;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= sel_count;
        mode_q     <= sel_mode;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end else if (state == SHIFT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    do_ror = (state == SHIFT) && (mode_q == USR_ROR);
    do_rol = (state == SHIFT) && (mode_q == USR_ROL);
  end

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .ror   (do_ror),
    .rol   (do_rol),
    .data  (sel_data),
    .q     (reg_q)
  );

  always_comb begin
    rsp_valid = (state == RESP);
    rsp_data  = reg_q;
    rsp_id    = id_q;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer: timeline model with an expected-result queue checked
// every cycle, plus directed commands with hand-computed results and latencies.
module tb_usr_sequencer;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_mode = '0, req1_mode = '0;
  logic [CNT_W-1:0] req0_count = '0, req1_count = '0;
  logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_mode  (req0_mode),
    .req0_count (req0_count),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_mode  (req1_mode),
    .req1_count (req1_count),
    .req1_data  (req1_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Result of a command from arithmetic rotation of the loaded value.
  function automatic logic [WIDTH-1:0] model_result(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] m,
                                                    input int c);
    logic [2*WIDTH-1:0] dbl;
    int k;
    dbl = {d, d};
    if (m == USR_ROR)      k = c % WIDTH;
    else if (m == USR_ROL) k = (WIDTH - (c % WIDTH)) % WIDTH;
    else                   k = 0;
    dbl = dbl >> k;
    return dbl[WIDTH-1:0];
  endfunction

  logic [WIDTH:0] exp_q[$];   // {id, data}
  int  cyc = 0;
  bit  m_busy = 0;
  int  m_from = 0;
  bit  m_fav = 0;             // requester favoured on a contested grant

  always @(negedge clk) begin
    bit e_valid, e_r0, e_r1, g;
    logic [1:0] m;
    logic [WIDTH-1:0] d;
    int c;
    cyc++;
    if (!rst_n) begin
      check("rst rsp_valid", int'(rsp_valid), 0);
      check("rst rsp_data", int'(rsp_data), 0);
      check("rst rsp_id", int'(rsp_id), 0);
      check("rst busy", int'(busy), 0);
      check("rst req0_ready", int'(req0_ready), 0);
      check("rst req1_ready", int'(req1_ready), 0);
      m_busy = 0;
      m_fav  = 0;
      exp_q.delete();
    end else begin
      e_valid = m_busy && (cyc >= m_from);
      e_r0 = 0;
      e_r1 = 0;
      if (!m_busy) begin
        if (req0_valid && (!req1_valid || !m_fav)) e_r0 = 1;
        else if (req1_valid)                       e_r1 = 1;
      end
      check("rsp_valid", int'(rsp_valid), int'(e_valid));
      check("busy", int'(busy), int'(m_busy));
      check("req0_ready", int'(req0_ready), int'(e_r0));
      check("req1_ready", int'(req1_ready), int'(e_r1));
      if (e_valid && exp_q.size() > 0) begin
        check("rsp_data", int'(rsp_data), int'(exp_q[0][WIDTH-1:0]));
        check("rsp_id", int'(rsp_id), int'(exp_q[0][WIDTH]));
      end
      if (e_valid && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_busy = 0;
      end else if (e_r0 || e_r1) begin
        g = e_r1;
        m = g ? req1_mode : req0_mode;
        d = g ? req1_data : req0_data;
        c = int'(g ? req1_count : req0_count);
        exp_q.push_back({g, model_result(d, m, c)});
        m_busy = 1;
        m_from = cyc + (((m == USR_ROR || m == USR_ROL) && c != 0) ? c + 1 : 1);
        m_fav  = ~g;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit p, input logic v, input logic [WIDTH-1:0] d,
                         input logic [1:0] m, input logic [CNT_W-1:0] c);
    if (p) begin
      req1_valid = v; req1_data = d; req1_mode = m; req1_count = c;
    end else begin
      req0_valid = v; req0_data = d; req0_mode = m; req0_count = c;
    end
  endtask

  // Offer a command; returns once it is accepted (1) or the budget expires (0).
  task automatic offer(input string name, input bit p, input logic [WIDTH-1:0] d,
                       input logic [1:0] m, input logic [CNT_W-1:0] c, output bit got);
    @(posedge clk); #1;
    set_req(p, 1'b1, d, m, c);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (p ? req1_ready : req0_ready) got = 1;
    end
    check({name, " accept"}, int'(got), 1);
    @(posedge clk); #1;
    set_req(p, 1'b0, '0, '0, '0);
  endtask

  task automatic send_and_check(input string name, input bit p, input logic [WIDTH-1:0] d,
                                input logic [1:0] m, input logic [CNT_W-1:0] c,
                                input logic [WIDTH-1:0] exp_d, input int exp_lat);
    bit got;
    int k;
    offer(name, p, d, m, c, got);
    if (got) begin
      got = 0;
      k = 0;
      for (int i = 1; i <= 40 && !got; i++) begin
        @(negedge clk);
        if (rsp_valid) begin
          got = 1;
          k = i;
        end
      end
      check({name, " latency"}, k, exp_lat);
      check({name, " data"}, int'(rsp_data), int'(exp_d));
      check({name, " id"}, int'(rsp_id), int'(p));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    int g[4];
    int n;
    int seen;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    send_and_check("ror1", 1'b0, 4'b1001, USR_ROR, 3'd1, 4'b1100, 2);
    send_and_check("rol3", 1'b1, 4'b0001, USR_ROL, 3'd3, 4'b1000, 4);
    send_and_check("hold", 1'b0, 4'b1010, USR_HOLD, 3'd5, 4'b1010, 1);
    send_and_check("load", 1'b1, 4'b0110, USR_LOAD, 3'd7, 4'b0110, 1);
    send_and_check("ror0", 1'b0, 4'b0011, USR_ROR, 3'd0, 4'b0011, 1);
    send_and_check("ror6wrap", 1'b1, 4'b0001, USR_ROR, 3'd6, 4'b0100, 7);

    // Both requesters valid continuously right after reset.
    pulse_reset();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0001, USR_LOAD, 3'd0);
    set_req(1'b1, 1'b1, 4'b0010, USR_LOAD, 3'd0);
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check("arb both ready", 1, 0);
      if (req0_ready)      begin g[n] = 0; n++; end
      else if (req1_ready) begin g[n] = 1; n++; end
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    check("arb grant count", n, 4);
    check("arb grant0", g[0], 0);
    check("arb grant1", g[1], 1);
    check("arb grant2", g[2], 0);
    check("arb grant3", g[3], 1);
    repeat (3) @(negedge clk);

    // Response back-pressure with a pending request on the other port.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0101, USR_LOAD, 3'd0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready) got = 1;
    end
    check("stall accept", int'(got), 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b1, 4'b1110, USR_LOAD, 3'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall rsp_valid", int'(rsp_valid), 1);
      check("stall rsp_data", int'(rsp_data), 4'b0101);
      check("stall rsp_id", int'(rsp_id), 0);
      check("stall busy", int'(busy), 1);
      check("stall ready", int'({req0_ready, req1_ready}), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("handshake cycle req1_ready", int'(req1_ready), 0);
    @(negedge clk);
    check("after handshake req1_ready", int'(req1_ready), 1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("queued rsp_valid", int'(rsp_valid), 1);
    check("queued rsp_data", int'(rsp_data), 4'b1110);
    check("queued rsp_id", int'(rsp_id), 1);

    // Reset in the middle of a count-5 rotation aborts it.
    offer("abort", 1'b1, 4'b1011, USR_ROR, 3'd5, got);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort rsp_valid", int'(rsp_valid), 0);
    check("abort rsp_data", int'(rsp_data), 0);
    check("abort rsp_id", int'(rsp_id), 0);
    check("abort busy", int'(busy), 0);
    check("abort ready", int'({req0_ready, req1_ready}), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort no response", seen, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 4'b0111, USR_LOAD, 3'd0);
    set_req(1'b1, 1'b1, 4'b1000, USR_LOAD, 3'd0);
    @(negedge clk);
    check("post reset grant req0", int'(req0_ready), 1);
    check("post reset req1 waits", int'(req1_ready), 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
